// File: rtl/debounce_sync.sv
// Switch debouncer: two-flop synchronizer feeding a
// four-state stability FSM with registered level and edge pulses.
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q,
    output logic notq,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        WAIT_HIGH = 2'b01,
        HIGH      = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             q_n;
    logic             rise_n;
    logic             fall_n;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d_raw;
            s2 <= s1;
        end
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            q     <= 1'b0;
            notq  <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            notq  <= ~q_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    // Next-state logic: qualify a level change over STABLE_CYCLES samples.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            LOW: begin
                if (s2) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = ONE;
                end else begin
                    cnt_n   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = HIGH;
                    q_n     = 1'b1;
                    rise_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + ONE;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = WAIT_LOW;
                    cnt_n   = ONE;
                end else begin
                    cnt_n   = '0;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = LOW;
                    q_n     = 1'b0;
                    fall_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt + ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
                q_n     = 1'b0;
            end
        endcase
    end

    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with STABLE_CYCLES=4,
// including a downstream enabled flop fed by q.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst;
    logic d_raw;
    logic q;
    logic notq;
    logic rise;
    logic fall;
    logic busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic       ff_q   = 1'b0;
    logic       e      = 1'b0;
    logic [1:0] ediv   = 2'd0;
    logic       both_hi = 1'b0;
    logic       nq_bad  = 1'b0;

    debounce_sync #(
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d_raw(d_raw),
        .q    (q),
        .notq (notq),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Downstream d flip-flop with an enable toggling every 2 cycles.
    always @(posedge clk) begin
        ediv <= ediv + 2'd1;
        e    <= ediv[1];
        if (e) ff_q <= q;
    end

    // Sticky monitors for invariants that must hold every cycle.
    always @(negedge clk) begin
        if (rise && fall) both_hi <= 1'b1;
        if (notq !== ~q) nq_bad <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        rst   = 1'b1;
        d_raw = 1'b0;
        tick();
        tick();
        check("rst_q", q, 0);
        check("rst_notq", notq, 1);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_busy", busy, 0);

        // Clean rising step: q rises 5 edges after first high sample.
        rst   = 1'b0;
        d_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("step_q", q, 0);
            check("step_rise", rise, 0);
            check("step_busy", busy, (i >= 2) ? 1 : 0);
        end
        tick();
        check("step_q1", q, 1);
        check("step_notq", notq, 0);
        check("step_rise1", rise, 1);
        check("step_busy0", busy, 0);
        tick();
        check("step_rise_done", rise, 0);
        check("step_q_hold", q, 1);

        // Falling step.
        d_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fall_q", q, 1);
            check("fall_pulse", fall, 0);
            check("fall_busy", busy, (i >= 2) ? 1 : 0);
        end
        tick();
        check("fall_q0", q, 0);
        check("fall_fall1", fall, 1);
        check("fall_rise0", rise, 0);
        tick();
        check("fall_done", fall, 0);

        // Bounce: 1,0,1,0 then steady 1.
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            d_raw = pat[i];
            tick();
            check("bnc_rise", rise, 0);
            check("bnc_q", q, 0);
        end
        d_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bnc_hold_rise", rise, 0);
            check("bnc_hold_q", q, 0);
        end
        check("chain_no_bounce", ff_q, 0);
        tick();
        check("bnc_q1", q, 1);
        check("bnc_rise1", rise, 1);
        tick();
        tick();
        tick();
        check("chain_follow", ff_q, 1);

        // Glitch: 3 low samples while q=1.
        d_raw = 1'b0;
        tick();
        tick();
        tick();
        d_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("gl_q", q, 1);
            check("gl_fall", fall, 0);
            if (i == 0) check("gl_busy_mid", busy, 1);
        end
        check("gl_busy_end", busy, 0);
        check("chain_glitch", ff_q, 1);

        // Reset mid-WAIT_HIGH at cnt=2, then restart.
        rst   = 1'b1;
        d_raw = 1'b0;
        tick();
        tick();
        check("rst2_q", q, 0);
        rst   = 1'b0;
        d_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_q", q, 0);
        check("mid_busy0", busy, 0);
        check("mid_rise", rise, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("re_rise", rise, 0);
        end
        tick();
        check("re_rise1", rise, 1);
        check("re_q1", q, 1);

        check("never_both", both_hi, 0);
        check("notq_inv", nq_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
